// File: rtl/strobe_generator_channel.sv
// ----------------------------------------------------------------------------
// StrobeGeneratorChannel
//
// One independent waveform channel. It holds an active configuration (period,
// high time, one-shot) that drives the running counter, plus a shadow copy that
// a configuration write lands in while the channel is busy. The shadow is
// promoted at the next period boundary, so a running period is never cut short.
//
// Ports:
//   clock      - sole clock, everything on the rising edge
//   clear      - synchronous active-high reset
//   i_enable   - level-sensitive run enable; a rising edge starts the channel
//   i_write    - accepted configuration write aimed at this channel
//   i_period   - written period in cycles (0 keeps the channel silent)
//   i_high     - written number of high cycles per period
//   i_oneshot  - written mode: 1 = run one period then stop
//   o_pending  - a shadow configuration is waiting to be promoted
//   o_wave     - registered periodic waveform
//   o_strobe   - registered one-cycle pulse at every period start
//   o_done     - one-shot finished, held until enable drops
// ----------------------------------------------------------------------------
module strobe_generator_channel #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     i_enable,
  input  logic                     i_write,
  input  logic [COUNTER_WIDTH-1:0] i_period,
  input  logic [COUNTER_WIDTH-1:0] i_high,
  input  logic                     i_oneshot,
  output logic                     o_pending,
  output logic                     o_wave,
  output logic                     o_strobe,
  output logic                     o_done
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                   r_state, w_state;
  logic [COUNTER_WIDTH-1:0] r_count, w_count;
  logic [COUNTER_WIDTH-1:0] r_period, w_period;
  logic [COUNTER_WIDTH-1:0] r_high, w_high;
  logic [COUNTER_WIDTH-1:0] r_shPeriod, w_shPeriod;
  logic [COUNTER_WIDTH-1:0] r_shHigh, w_shHigh;
  logic                     r_oneshot, w_oneshot;
  logic                     r_shOneshot, w_shOneshot;
  logic                     r_pending, w_pending;
  logic                     r_enablePrev;
  logic                     r_armed, w_armed;
  logic                     r_wave, w_wave;
  logic                     r_strobe, w_strobe;
  logic                     r_done, w_done;
  logic                     w_rise;
  logic                     w_wrap;

  assign w_rise = i_enable && !r_enablePrev;
  assign w_wrap = (r_count == r_period - COUNTER_WIDTH'(1));

  // Next-state logic. The outputs are a registered view of the current
  // state/count, so the first strobe shows up one edge after the start edge.
  // Outputs are gated by the live enable so a dropped enable silences the
  // channel on the very edge that samples it.
  // r_armed remembers an enable edge that arrived while the active period was
  // zero, so that a later write with a real period starts the channel at once.
  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_period    = r_period;
    w_high      = r_high;
    w_oneshot   = r_oneshot;
    w_shPeriod  = r_shPeriod;
    w_shHigh    = r_shHigh;
    w_shOneshot = r_shOneshot;
    w_pending   = r_pending;
    w_armed     = r_armed;
    w_wave      = 1'b0;
    w_strobe    = 1'b0;
    w_done      = 1'b0;

    if (i_enable) begin
      if (r_state == ST_RUNNING) begin
        w_wave   = (r_count < r_high);
        w_strobe = (r_count == '0);
      end else if (r_state == ST_DONE) begin
        w_done = 1'b1;
      end
    end

    // A shadow left over from a channel that has since stopped is promoted now.
    if (r_pending && (r_state != ST_RUNNING)) begin
      w_period  = r_shPeriod;
      w_high    = r_shHigh;
      w_oneshot = r_shOneshot;
      w_pending = 1'b0;
    end

    // Writes to an idle channel take effect immediately; writes to a running
    // channel wait in the shadow for the period boundary.
    if (i_write) begin
      if (r_state != ST_RUNNING) begin
        w_period  = i_period;
        w_high    = i_high;
        w_oneshot = i_oneshot;
      end else begin
        w_shPeriod  = i_period;
        w_shHigh    = i_high;
        w_shOneshot = i_oneshot;
        w_pending   = 1'b1;
      end
    end

    case (r_state)
      ST_STOPPED: begin
        w_count = '0;
        if (!i_enable) begin
          w_armed = 1'b0;
        end else if (w_rise || r_armed) begin
          if (w_period != '0) begin
            w_state = ST_RUNNING;
            w_armed = 1'b0;
          end else begin
            w_armed = 1'b1;
          end
        end
      end
      ST_RUNNING: begin
        if (!i_enable) begin
          w_state = ST_STOPPED;
          w_count = '0;
        end else if (w_wrap) begin
          w_count = '0;
          if (r_pending) begin
            w_period  = r_shPeriod;
            w_high    = r_shHigh;
            w_oneshot = r_shOneshot;
            w_pending = 1'b0;
          end
          if (r_oneshot) begin
            w_state = ST_DONE;
          end else if (w_period == '0) begin
            w_state = ST_STOPPED;
            w_armed = 1'b1;
          end
        end else begin
          w_count = r_count + COUNTER_WIDTH'(1);
        end
      end
      ST_DONE: begin
        w_count = '0;
        if (!i_enable) begin
          w_state = ST_STOPPED;
        end
      end
      default: begin
        w_state = ST_STOPPED;
        w_count = '0;
      end
    endcase
  end

  // State register; clear wipes configuration, history and outputs alike.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state      <= ST_STOPPED;
      r_count      <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_oneshot    <= 1'b0;
      r_shPeriod   <= '0;
      r_shHigh     <= '0;
      r_shOneshot  <= 1'b0;
      r_pending    <= 1'b0;
      r_enablePrev <= 1'b0;
      r_armed      <= 1'b0;
      r_wave       <= 1'b0;
      r_strobe     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_count      <= w_count;
      r_period     <= w_period;
      r_high       <= w_high;
      r_oneshot    <= w_oneshot;
      r_shPeriod   <= w_shPeriod;
      r_shHigh     <= w_shHigh;
      r_shOneshot  <= w_shOneshot;
      r_pending    <= w_pending;
      r_enablePrev <= i_enable;
      r_armed      <= w_armed;
      r_wave       <= w_wave;
      r_strobe     <= w_strobe;
      r_done       <= w_done;
    end
  end

  assign o_pending = r_pending;
  assign o_wave    = r_wave;
  assign o_strobe  = r_strobe;
  assign o_done    = r_done;

endmodule

// File: rtl/multi_channel_strobe_generator.sv
// ----------------------------------------------------------------------------
// MultiChannelStrobeGenerator
//
// CHANNEL_COUNT independent strobe/waveform channels sharing one configuration
// write port with a valid/ready handshake. A channel refuses new writes while
// it still has an unpromoted shadow configuration.
//
// Ports:
//   clock          - sole clock
//   clear          - synchronous active-high reset
//   config_valid   - configuration write request
//   config_ready   - write accepted when high together with config_valid
//   config_channel - target channel of the write
//   config_period  - period in cycles, 0 = silent
//   config_high    - high cycles per period
//   config_oneshot - 1 = single period, 0 = free-running
//   enable         - per-channel run enable
//   wave_out       - per-channel waveform
//   strobe_out     - per-channel period-start pulse
//   done_out       - per-channel one-shot completion flag
// ----------------------------------------------------------------------------
module multi_channel_strobe_generator #(
  parameter  int CHANNEL_COUNT = 4,
  parameter  int COUNTER_WIDTH = 16,
  localparam int INDEX_WIDTH   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     config_valid,
  output logic                     config_ready,
  input  logic [INDEX_WIDTH-1:0]   config_channel,
  input  logic [COUNTER_WIDTH-1:0] config_period,
  input  logic [COUNTER_WIDTH-1:0] config_high,
  input  logic                     config_oneshot,
  input  logic [CHANNEL_COUNT-1:0] enable,
  output logic [CHANNEL_COUNT-1:0] wave_out,
  output logic [CHANNEL_COUNT-1:0] strobe_out,
  output logic [CHANNEL_COUNT-1:0] done_out
);

  logic [CHANNEL_COUNT-1:0] w_pending;
  logic [CHANNEL_COUNT-1:0] w_chanWrite;
  logic                     w_write;

  // Ready follows the addressed channel's pending flag. An index beyond the
  // last channel (non power-of-two counts) is never ready, so it cannot write.
  always_comb begin
    config_ready = 1'b0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (config_channel == INDEX_WIDTH'(i)) begin
        config_ready = !w_pending[i];
      end
    end
  end

  assign w_write = config_valid && config_ready;

  // Decode the accepted write into a one-hot per-channel strobe.
  always_comb begin
    w_chanWrite = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      w_chanWrite[i] = w_write && (config_channel == INDEX_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : gen_channel
    strobe_generator_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_channel (
      .clock     (clock),
      .clear     (clear),
      .i_enable  (enable[g]),
      .i_write   (w_chanWrite[g]),
      .i_period  (config_period),
      .i_high    (config_high),
      .i_oneshot (config_oneshot),
      .o_pending (w_pending[g]),
      .o_wave    (wave_out[g]),
      .o_strobe  (strobe_out[g]),
      .o_done    (done_out[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_strobe_generator.sv
// ----------------------------------------------------------------------------
// Testbench for multi_channel_strobe_generator: a per-cycle vector table on
// channel 0, then hand-written multi-cycle sequences for shadow promotion,
// clear mid-period and concurrent channels.
// ----------------------------------------------------------------------------
module tb_multi_channel_strobe_generator;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          clock = 1'b0;
  logic          clear;
  logic          config_valid;
  logic          config_ready;
  logic [1:0]    config_channel;
  logic [W-1:0]  config_period;
  logic [W-1:0]  config_high;
  logic          config_oneshot;
  logic [CH-1:0] enable;
  logic [CH-1:0] wave_out;
  logic [CH-1:0] strobe_out;
  logic [CH-1:0] done_out;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic       clr;
    logic [3:0] en;
    logic       vld;
    int         per;
    int         hi;
    logic       os;
    logic [3:0] expWave;
    logic [3:0] expStrobe;
    logic [3:0] expDone;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  multi_channel_strobe_generator #(
    .CHANNEL_COUNT(CH),
    .COUNTER_WIDTH(W)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .config_valid   (config_valid),
    .config_ready   (config_ready),
    .config_channel (config_channel),
    .config_period  (config_period),
    .config_high    (config_high),
    .config_oneshot (config_oneshot),
    .enable         (enable),
    .wave_out       (wave_out),
    .strobe_out     (strobe_out),
    .done_out       (done_out)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    clear          = v.clr;
    enable         = v.en;
    config_valid   = v.vld;
    config_channel = 2'd0;
    config_period  = W'(v.per);
    config_high    = W'(v.hi);
    config_oneshot = v.os;
    tick();
  endtask

  task automatic writeConfig(input logic [1:0] ch, input int per, input int hi, input logic os);
    config_channel = ch;
    config_period  = W'(per);
    config_high    = W'(hi);
    config_oneshot = os;
    config_valid   = 1'b1;
    tick();
    config_valid   = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic void addVec(input logic clr, input logic [3:0] en, input logic vld,
                                 input int per, input int hi, input logic os,
                                 input logic [3:0] w, input logic [3:0] s, input logic [3:0] d);
    vec_t v;
    v.clr = clr; v.en = en; v.vld = vld; v.per = per; v.hi = hi; v.os = os;
    v.expWave = w; v.expStrobe = s; v.expDone = d;
    vecs.push_back(v);
  endfunction

  initial begin
    int seqStrobe[9];
    int seqReady[9];
    logic [3:0] conStrobe[6];

    clear = 1'b1; enable = '0; config_valid = 1'b0; config_channel = '0;
    config_period = '0; config_high = '0; config_oneshot = 1'b0;

    // Channel 0: each row is the inputs before an edge and the outputs after it.
    addVec(1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    // free-running period 4, high 2
    addVec(0, 4'h0, 1, 4, 2, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    // one-shot period 3, high 1
    addVec(0, 4'h0, 1, 3, 1, 1, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1);
    addVec(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    // period 4, high 0: strobes only
    addVec(0, 4'h0, 1, 4, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h1, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h1, 4'h0);
    addVec(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    // period 4, high 7: wave stuck high
    addVec(0, 4'h0, 1, 4, 7, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    // period 1: strobe and wave every cycle
    addVec(0, 4'h0, 1, 1, 1, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
    addVec(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_wave", i), 32'(wave_out), 32'(vecs[i].expWave));
      checkOutput($sformatf("vec%0d_strobe", i), 32'(strobe_out), 32'(vecs[i].expStrobe));
      checkOutput($sformatf("vec%0d_done", i), 32'(done_out), 32'(vecs[i].expDone));
    end
    clear = 1'b0;
    enable = '0;

    // Shadow promotion: period 5 running, period 2 written at count 1.
    pulseClear();
    config_channel = 2'd2;
    #1;
    checkOutput("reset_ready", 32'(config_ready), 32'd1);
    writeConfig(2'd2, 5, 2, 1'b0);
    enable = 4'b0100;
    tick();
    seqStrobe = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
    seqReady  = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) begin
        config_channel = 2'd2; config_period = W'(2); config_high = W'(1);
        config_oneshot = 1'b0; config_valid = 1'b1;
      end
      tick();
      config_valid = 1'b0;
      checkOutput($sformatf("swap_strobe_%0d", k), 32'(strobe_out[2]), 32'(seqStrobe[k-1]));
      checkOutput($sformatf("swap_ready_%0d", k), 32'(config_ready), 32'(seqReady[k-1]));
    end
    enable = '0;
    tick();

    // Clear in mid-period with enable held high, then restart by reconfiguring.
    pulseClear();
    writeConfig(2'd0, 4, 2, 1'b0);
    enable = 4'b0001;
    tick();
    tick();
    tick();
    checkOutput("preclear_wave", 32'(wave_out[0]), 32'd1);
    clear = 1'b1;
    tick();
    checkOutput("clear_outputs", 32'({wave_out, strobe_out, done_out}), 32'd0);
    config_channel = 2'd0;
    #1;
    checkOutput("clear_ready", 32'(config_ready), 32'd1);
    clear = 1'b0;
    tick();
    checkOutput("postclear_idle1", 32'({wave_out, strobe_out}), 32'd0);
    tick();
    checkOutput("postclear_idle2", 32'({wave_out, strobe_out}), 32'd0);
    writeConfig(2'd0, 3, 1, 1'b0);
    checkOutput("restart_edge", 32'({wave_out, strobe_out}), 32'd0);
    tick();
    checkOutput("restart_strobe", 32'(strobe_out[0]), 32'd1);
    checkOutput("restart_wave", 32'(wave_out[0]), 32'd1);
    tick();
    checkOutput("restart_c1", 32'({wave_out[0], strobe_out[0]}), 32'd0);
    tick();
    checkOutput("restart_c2", 32'({wave_out[0], strobe_out[0]}), 32'd0);
    tick();
    checkOutput("restart_again", 32'(strobe_out[0]), 32'd1);
    enable = '0;
    tick();

    // Channels 0 and 3 together; a write to idle channel 1 mid-run.
    pulseClear();
    writeConfig(2'd0, 2, 1, 1'b0);
    writeConfig(2'd3, 3, 1, 1'b0);
    enable = 4'b1001;
    tick();
    conStrobe = '{4'b1001, 4'b0000, 4'b0001, 4'b1000, 4'b0001, 4'b0000};
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) begin
        config_channel = 2'd1; config_period = W'(5); config_high = W'(2);
        config_oneshot = 1'b0; config_valid = 1'b1;
      end
      tick();
      config_valid = 1'b0;
      checkOutput($sformatf("multi_strobe_%0d", k), 32'(strobe_out), 32'(conStrobe[k-1]));
      checkOutput($sformatf("multi_wave_%0d", k), 32'(wave_out), 32'(conStrobe[k-1]));
    end
    enable = '0;
    tick();
    checkOutput("multi_stop", 32'({wave_out, strobe_out, done_out}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
